tone_detect: RTL

- Receive-side counterpart to the buzzer tone generator.
- Measures the period of an incoming square-wave tone and classifies it as one of the four note frequencies: 261.63, 277.18, 493.88 or 523.25 Hz.
- Reports the note on the same 2-bit state encoding the generator path uses.
- Sits on a board input pin (e.g. loopback from the buzzer net or an external tone source); feeds LED/display logic or self-test.

---
 rtl/tone_detect.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tone_detect.sv
// Square-wave tone period meter: measures rising-edge spacing and locks onto
// one of four note periods after MATCH_COUNT consecutive matching samples.
module tone_detect #(
  parameter int unsigned P_261       = 191110,
  parameter int unsigned P_277       = 180388,
  parameter int unsigned P_493       = 101239,
  parameter int unsigned P_523       = 95557,
  parameter int unsigned TOL         = 2000,
  parameter int unsigned MATCH_COUNT = 4,
  parameter int unsigned TIMEOUT     = 250000
) (
  input  logic        clk_50MHz,
  input  logic        reset,
  input  logic        tone_in,
  output logic [1:0]  state,
  output logic        valid,
  output logic        note_strobe,
  output logic [17:0] period
);

  localparam int unsigned MW        = $clog2(MATCH_COUNT + 1);
  localparam logic [17:0] TIMEOUT_C = 18'(TIMEOUT);
  localparam logic [31:0] NOM [4]   = '{32'(P_261), 32'(P_277), 32'(P_493), 32'(P_523)};

  typedef enum logic [1:0] {SILENT, MEASURE, LOCKED} fsm_t;

  // Input synchronizer and rising-edge detector
  logic       sync0_q, sync1_q, sync2_q;
  logic [1:0] fill_q;
  logic       edge_q;

  // fill_q keeps reset-value zeros in the pipeline from looking like a rise
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      fill_q  <= 2'd0;
      edge_q  <= 1'b0;
    end else begin
      sync0_q <= tone_in;
      sync1_q <= sync0_q;
      sync2_q <= sync1_q;
      if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
      edge_q  <= sync1_q & ~sync2_q & (fill_q == 2'd3);
    end
  end

  // Saturating period counter
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] sample;
  logic        timeout;

  assign sample  = cnt_q + 18'd1;
  assign timeout = (cnt_q == TIMEOUT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (edge_q)        cnt_d = '0;
    else if (!timeout) cnt_d = cnt_q + 18'd1;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Window classifier; TOL is added on the sample side to avoid underflow
  logic [31:0] sample_w;
  logic [3:0]  hit;
  logic        cls_hit;
  logic [1:0]  cls;

  assign sample_w = {14'd0, sample};

  for (genvar gi = 0; gi < 4; gi++) begin : g_cls
    assign hit[gi] = (sample_w + 32'(TOL) >= NOM[gi]) && (sample_w <= NOM[gi] + 32'(TOL));
  end

  always_comb begin
    cls_hit = |hit;
    cls     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      if (hit[k]) cls = 2'(k);
    end
  end

  // Lock FSM with registered outputs
  fsm_t          fsm_q;
  logic [1:0]    state_q, cand_q;
  logic          valid_q, strobe_q;
  logic [17:0]   period_q;
  logic [MW-1:0] match_q, match_step;

  assign match_step = (cls == cand_q) ? match_q + MW'(1) : MW'(1);

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      fsm_q    <= SILENT;
      state_q  <= 2'd0;
      cand_q   <= 2'd0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      period_q <= '0;
      match_q  <= '0;
    end else begin
      strobe_q <= 1'b0;
      case (fsm_q)
        SILENT: begin
          if (edge_q) begin
            fsm_q   <= MEASURE;
            match_q <= '0;
          end
        end
        MEASURE: begin
          if (edge_q) begin
            period_q <= sample;
            if (!cls_hit) begin
              match_q <= '0;
            end else begin
              cand_q  <= cls;
              match_q <= match_step;
              if (match_step == MW'(MATCH_COUNT)) begin
                fsm_q    <= LOCKED;
                state_q  <= cls;
                valid_q  <= 1'b1;
                strobe_q <= 1'b1;
              end
            end
          end else if (timeout) begin
            fsm_q   <= SILENT;
            valid_q <= 1'b0;
          end
        end
        LOCKED: begin
          if (edge_q) begin
            period_q <= sample;
            if (!(cls_hit && (cls == state_q))) begin
              fsm_q   <= MEASURE;
              valid_q <= 1'b0;
              cand_q  <= cls;
              match_q <= cls_hit ? MW'(1) : '0;
            end
          end else if (timeout) begin
            fsm_q   <= SILENT;
            valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q   <= SILENT;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign state       = state_q;
  assign valid       = valid_q;
  assign note_strobe = strobe_q;
  assign period      = period_q;

endmodule
